// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle wide adder that sums two W = N*CHUNKS bit
// operands one N-bit chunk per cycle through a single N-bit ripple-carry stage,
// LSB chunk first, holding the inter-chunk carry in a register.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin   W-bit operands and LSB carry-in
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   out_sum, out_cout    registered sum mod 2^W and MSB carry-out
//   busy                 high in RUN or DONE
//
// full_adder: N-bit ripple-carry adder stage (combinational).
//   a, b, cin -> s, cout

module full_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    // Bit-serial ripple through the chunk
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < int'(N); i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

module wide_add_sequencer #(
    parameter int unsigned N      = 4,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*CHUNKS-1:0]   in_a,
    input  logic [N*CHUNKS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*CHUNKS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  busy
);

    localparam int unsigned W     = N * CHUNKS;
    localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     res_reg;
    logic [W-1:0]     res_next;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [N-1:0]     fa_a;
    logic [N-1:0]     fa_b;
    logic [N-1:0]     fa_s;
    logic             fa_cout;

    // Handshake/status flags decode from state, forced low while reset is asserted
    assign in_ready  = ~rst & (state == S_IDLE);
    assign out_valid = ~rst & (state == S_DONE);
    assign busy      = ~rst & ((state == S_RUN) | (state == S_DONE));

    assign last = (idx == IDX_W'(CHUNKS - 1));

    // Select the current chunk and splice the stage result into the partial sum
    always_comb begin
        fa_a     = a_reg[32'(idx) * N +: N];
        fa_b     = b_reg[32'(idx) * N +: N];
        res_next = res_reg;
        res_next[32'(idx) * N +: N] = fa_s;
    end

    full_adder #(.N(N)) u_stage (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid)  state_next = S_RUN;
            S_RUN:   if (last)      state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, chunk accumulation, result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                    end
                end
                S_RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= fa_cout;
                    if (last) begin
                        idx      <= '0;
                        out_sum  <= res_next;
                        out_cout <= fa_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed-vector scoreboard bench for wide_add_sequencer.
// u0 is the N=4, CHUNKS=4 instance; u1 is the N=4, CHUNKS=1 instance.
// Drivers push hand-computed results with their expected out_valid cycle;
// per-instance monitors pop and compare on each rising out_valid.

module tb_wide_add_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = N * CH;

    logic         clk = 1'b0;
    logic         rst;

    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [W-1:0] in_a, in_b, out_sum;

    logic         in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
    logic [N-1:0] in_a1, in_b1, out_sum1;

    always #5 clk = ~clk;

    wide_add_sequencer #(.N(N), .CHUNKS(CH)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    wide_add_sequencer #(.N(N), .CHUNKS(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for u0: compare on each rising out_valid
    logic pv0 = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid && !pv0) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("u0_sum", 32'(out_sum), 32'(e0.sum));
                check("u0_cout", 32'(out_cout), 32'(e0.cout));
                check("u0_latency", cyc, e0.due);
            end
        end
        pv0 = out_valid;
    end

    // Monitor for u1
    logic pv1 = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid1 && !pv1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("u1_sum", 32'(out_sum1), 32'(e1.sum));
                check("u1_cout", 32'(out_cout1), 32'(e1.cout));
                check("u1_latency", cyc, e1.due);
            end
        end
        pv1 = out_valid1;
    end

    // Present an operand pair to u0 and wait for acceptance; called just after a negedge.
    // Returns at the negedge following the accepting edge (acc = that cycle number).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit push, input logic [15:0] esum, input logic ecout,
                         output int acc);
        bit got;
        got      = 1'b0;
        acc      = -1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                got = 1'b1;
                acc = cyc + 1;
                if (push) q0.push_back('{esum, ecout, cyc + 1 + int'(CH)});
                break;
            end
            @(negedge clk);
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2, seen;

        rst        = 1'b1;
        in_valid   = 1'b0; in_a  = '0; in_b  = '0; in_cin  = 1'b0; out_ready  = 1'b1;
        in_valid1  = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        check("rst_out_valid_low", 32'(out_valid), 32'd0);
        check("rst_busy_low", 32'(busy), 32'd0);
        check("rst_u1_in_ready_low", 32'(in_ready1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_sum", 32'(out_sum), 32'd0);
        check("post_rst_cout", 32'(out_cout), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 1: full carry propagation across all chunks
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, acc);
        in_valid = 1'b0;
        wait_idle("t1_idle_timeout");

        // 2: busy / in_ready profile around one operation
        issue(16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, acc);
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t2_busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("t2_in_ready_c%0d", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_in_ready_after", 32'(in_ready), 32'd1);

        // 3: backpressure holds result, new operand not taken
        out_ready = 1'b0;
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h1010, 1'b0, acc);
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_valid = 1'b1;
        wait_valid("t3_valid_timeout");
        for (int c = 0; c < 6; c++) begin
            check("t3_valid_held", 32'(out_valid), 32'd1);
            check("t3_sum_stable", 32'(out_sum), 32'h1010);
            check("t3_cout_stable", 32'(out_cout), 32'd0);
            check("t3_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("t3_in_ready_after", 32'(in_ready), 32'd1);
        check("t3_valid_dropped", 32'(out_valid), 32'd0);
        check("t3_sum_held_idle", 32'(out_sum), 32'h1010);

        // 4: reset mid-RUN at idx=2 aborts the operation
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, acc);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_sum_cleared", 32'(out_sum), 32'd0);
        check("t4_cout_cleared", 32'(out_cout), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("t4_no_valid_pulse", 32'(seen), 32'd0);

        // 5: back-to-back with in_valid and out_ready tied high
        out_ready = 1'b1;
        issue(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, acc1);
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1000, 1'b0, acc2);
        in_valid = 1'b0;
        check("t5_issue_interval", 32'(acc2 - acc1), 32'd6);
        wait_idle("t5_idle_timeout");

        // 6: CHUNKS=1 instance acts as registered N-bit adder
        in_a1 = 4'hF; in_b1 = 4'h1; in_cin1 = 1'b1; in_valid1 = 1'b1;
        check("t6_u1_ready", 32'(in_ready1), 32'd1);
        if (in_ready1) q1.push_back('{16'h0001, 1'b1, cyc + 2});
        @(negedge clk);
        in_a1 = 4'h7; in_b1 = 4'h8; in_cin1 = 1'b0;
        for (int i = 0; i < 10 && !in_ready1; i++) @(negedge clk);
        check("t6_u1_ready2", 32'(in_ready1), 32'd1);
        if (in_ready1) q1.push_back('{16'h000F, 1'b0, cyc + 2});
        @(negedge clk);
        in_valid1 = 1'b0;

        repeat (8) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
